// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage with latency-modelled word RAM, byte-lane alignment,
// sign/zero extension and rejection of misaligned or illegal requests.
module load_store_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rd_word, rd_shift, ld_data, st_data, st_word;
    logic [15:0]     rd_half;
    logic [3:0]      st_be;
    logic            mem_we, req_ill, req_mis, req_err;
    logic            unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    // Request legality is judged on the live inputs so a rejected request answers in one cycle.
    assign req_ill = we ? (funct3 >= 3'b011) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    assign req_mis = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign req_err = req_ill || req_mis;

    assign rd_word  = mem[addr_q[AW+1:2]];
    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
    assign rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    assign ld_data  = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & rd_shift[7]}}, rd_shift[7:0]} :
                      (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & rd_half[15]}}, rd_half} : rd_word;

    assign st_be   = (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                     (f3_q[1:0] == 2'b01) ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign st_data = (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                     (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;

    always_comb begin
        st_word = rd_word;
        for (int i = 0; i < 4; i++)
            if (st_be[i]) st_word[8*i +: 8] = st_data[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_we  = we_q;
                    rdata_d = we_q ? rdata_q : ld_data;
                    state_d = RESP;
                end
            end
            default: begin
                if (req) begin
                    addr_d  = addr[AW+1:0];
                    we_d    = we;
                    f3_d    = funct3;
                    wdata_d = wdata;
                    err_d   = req_err;
                    cnt_d   = req_err ? '0 : CW'(LATENCY - 1);
                    state_d = req_err ? RESP : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM has no reset; a reset in the final ACCESS cycle must still suppress the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[addr_q[AW+1:2]] <= st_word;
    end

    assign busy       = (state_q == ACCESS);
    assign done       = (state_q == RESP);
    assign misaligned = (state_q == RESP) && err_q;
    assign rdata      = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks against a byte-addressed memory model.
module tb_load_store_unit;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done, misaligned;
    logic [31:0] rdata;

    int n_chk = 0, n_err = 0;
    logic [7:0]  ram_m [4*DEPTH];
    logic [31:0] rdata_m = '0;
    logic        p_we;
    logic [2:0]  p_f3;
    logic [31:0] p_a, p_wd;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic w, input logic [2:0] f, input logic [31:0] a);
        bit legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || (int'(a[1:0]) % access_size(f) != 0);
    endfunction

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        p_we = w; p_f3 = f; p_a = a; p_wd = d;
    endtask

    task automatic finish_op();
        bit          e = model_err(p_we, p_f3, p_a);
        int          exp_k = e ? 1 : LAT + 1;
        int          sz = access_size(p_f3);
        int          ba = int'(p_a & 32'(4*DEPTH - 1));
        int          k;
        bit          busy_bad = 1'b0;
        logic [31:0] v = '0;
        @(posedge clk); #1;
        req = 1'b0;
        for (k = 1; k <= 20; k++) begin
            if (done) break;
            if (busy !== 1'b1) busy_bad = 1'b1;
            @(posedge clk); #1;
        end
        check("latency", k, exp_k);
        check("busy_in_flight", busy_bad, 0);
        check("busy_at_done", busy, 0);
        check("misaligned", misaligned, e);
        if (!e) begin
            if (p_we) begin
                for (int i = 0; i < sz; i++) ram_m[ba + i] = p_wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ram_m[ba + i];
                if (!p_f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                if (!p_f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                rdata_m = v;
            end
        end
        check("rdata", rdata, rdata_m);
    endtask

    task automatic op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input bit b2b);
        if (!b2b) begin
            @(posedge clk); #1;
            check("done_pulse", done, 0);
        end
        issue(w, f, a, d);
        finish_op();
    endtask

    initial begin
        bit stray_done;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mis", misaligned, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b0;
        for (int w = 0; w < 64; w++) op(1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0);

        op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
        op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        check("word_rt", rdata, 32'hDEADBEEF);

        op(1'b1, 3'd2, 32'h20, 32'h0, 1'b0);
        op(1'b1, 3'd0, 32'h23, 32'h80, 1'b0);
        op(1'b0, 3'd0, 32'h23, 32'h0, 1'b0);
        check("lb", rdata, 32'hFFFFFF80);
        op(1'b0, 3'd4, 32'h23, 32'h0, 1'b0);
        check("lbu", rdata, 32'h00000080);
        op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
        check("lw_after_sb", rdata, 32'h80000000);

        op(1'b1, 3'd2, 32'h40, 32'hAAAAAAAA, 1'b0);
        op(1'b1, 3'd1, 32'h42, 32'h00001234, 1'b0);
        op(1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
        check("lw_after_sh", rdata, 32'h1234AAAA);
        op(1'b0, 3'd5, 32'h42, 32'h0, 1'b0);
        check("lhu", rdata, 32'h00001234);
        op(1'b0, 3'd1, 32'h40, 32'h0, 1'b0);
        check("lh", rdata, 32'hFFFFAAAA);

        op(1'b0, 3'd2, 32'h02, 32'h0, 1'b0);
        check("mis_rdata_held", rdata, 32'hFFFFAAAA);
        op(1'b1, 3'd1, 32'h05, 32'hFFFF, 1'b0);
        op(1'b0, 3'd2, 32'h04, 32'h0, 1'b0);
        op(1'b0, 3'd3, 32'h00, 32'h0, 1'b0);

        @(posedge clk); #1;
        issue(1'b1, 3'd2, 32'h0, 32'h5);
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        rst = 1'b0;
        rdata_m = '0;
        stray_done = 1'b0;
        repeat (LAT + 3) begin
            if (done || busy) stray_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", stray_done, 0);
        check("abort_rdata", rdata, 0);
        op(1'b0, 3'd2, 32'h0, 32'h0, 1'b0);

        op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
        op(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

        op(1'b1, 3'd2, 32'h1000, 32'h77, 1'b0);
        op(1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
        check("wrap", rdata, 32'h77);

        repeat (300)
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory stage of the single-cycle/multi-cycle RISC-V datapath. It executes one load or store per request against an internal word-organised RAM with a configurable access latency. It performs byte-lane alignment, sign or zero extension and misalignment detection. Its registered `rdata` feeds the memory-data input (select `01`) of the write-back result 4-to-1 mux; `busy` stalls the datapath while an access is in flight.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at least 2.
- `LATENCY`, 2: access cycles per aligned request; at least 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  1  request strobe; sampled only in IDLE or RESP.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  width/sign:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `busy`  out  1  access in flight; datapath must hold.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load result; held between loads.
- `misaligned`  out  1  valid with `done`; request rejected.

## Operation
- FSM states are IDLE, ACCESS and RESP. A down-counter `cnt` is sized to hold LATENCY-1.
- **Request capture.** In IDLE or RESP, `req=1` captures `addr`, `we`, `funct3` and `wdata` on the edge.
- **Error check.** The captured request is checked combinationally:
  - Misaligned: LH, LHU or SH with `addr[0]=1`; LW or SW with `addr[1:0]≠0`.
  - Illegal encoding: load `funct3` in {011, 110, 111}; store `funct3` ≥ 011.
  - On error, go to RESP with error flag set. Memory is untouched and `rdata` is unchanged.
- **Normal path.** Otherwise go to ACCESS and load `cnt = LATENCY-1`.
- **ACCESS.** `busy=1` and `req` is ignored. While `cnt≠0`, decrement it. At `cnt=0`:
  - Perform the access.
  - For loads, register the result into `rdata`.
  - Go to RESP.
- **RESP.** `done=1` for this one cycle, and `misaligned` equals the error flag. Then:
  - `req=1`: capture the new request (back-to-back).
  - Otherwise return to IDLE.
- **Word index.** Word index is `addr[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- **Stores:**
  - SB writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH writes `wdata[15:0]` to lane `addr[1]` (bytes 2·addr[1] and 2·addr[1]+1).
  - SW writes the full word.
  - Other lanes are preserved, and `rdata` is unchanged by stores.
- **Loads.** The lane is selected the same way:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW returns the word.
- **Byte order.** Little-endian: lane 0 is bits [7:0].

## Timing
- **Reset state** (with `rst=1`): state IDLE, `cnt=0`, `busy=0`, `done=0`, `misaligned=0`, `rdata=0`, error flag 0. RAM contents are not cleared.
- **Reset mid-operation.** Reset during ACCESS aborts: no write occurs and no `done` is issued. Reset during RESP suppresses any pending capture.
- **Aligned request** with `req` high in cycle 0:
  - `busy=1` in cycles 1..LATENCY.
  - `done=1` in cycle LATENCY+1.
  - Load data is on `rdata` from cycle LATENCY+1 onward.
- **Back-to-back.** A `req` during the `done` cycle starts its ACCESS in the next cycle. Throughput is one access per LATENCY+1 cycles.
- **Rejected request.** `req` in cycle 0 gives `done=1` and `misaligned=1` in cycle 1; `busy` stays 0.
- **Output stability.** `busy`, `done` and `misaligned` are decoded from registered state only; none depends combinationally on inputs.
- **Read-after-write.** A load issued after a store's `done` observes the stored data.

## Test plan
- **Word round trip.** After reset, SW 0xDEADBEEF @0x10, then LW @0x10 → `rdata=0xDEADBEEF`. With LATENCY=2, `done` is at cycle 3 of each op and `busy=1` in cycles 1–2.
- **Byte store and signed/unsigned byte loads.**
  - SW 0 @0x20, then SB 0x80 @0x23.
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x23 → 0x00000080.
  - LW @0x20 → 0x80000000.
- **Halfword lane 1.**
  - SH 0x1234 @0x42 over existing word 0xAAAAAAAA → LW @0x40 returns 0x1234AAAA.
  - LHU @0x42 → 0x00001234.
  - LH @0x40 → 0xFFFFAAAA.
- **Misaligned and illegal requests.**
  - LW @0x02 → cycle 1 `done=1`, `misaligned=1`, `busy` never high, `rdata` unchanged.
  - SH @0x05 → same signalling, and a later LW @0x04 shows the prior contents.
  - `funct3=011` load → `misaligned=1`.
- **Reset during ACCESS and back-to-back.**
  - SW 0x5 @0x0 issued, then `rst` pulsed in cycle 1 → no `done`; LW @0x0 returns the old value.
  - Two LWs with the second `req` in the first one's `done` cycle → `done` pulses exactly LATENCY+1 cycles apart.
- **Wrap-around.** With DEPTH_WORDS=1024, SW 0x77 @0x1000 → LW @0x0 returns 0x77.
